// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with two-entry skid buffer and synchronous flush
// Parameters: DATA_W payload width (>=1), RESET_VAL value of out_data while/after reset.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous squash of all held entries, highest priority
//   in_valid   upstream payload valid
//   in_ready   stage can accept (registered, no path from out_ready)
//   in_data    upstream payload
//   out_valid  payload presented downstream
//   out_ready  downstream accepts
//   out_data   payload to next stage (registered)
// Optional (macro PIPE_STAGE_REG_PERF_EN):
//   stall_cnt  cycles with out_valid & !out_ready, wraps at 2^32
//   flush_cnt  cycles with flush while any entry is held, wraps at 2^32
module pipe_stage_reg #(
   parameter int DATA_W = 64,
   parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_REG_PERF_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);
   logic [DATA_W-1:0] skid_data;
   logic skid_valid, in_fire, out_fire, out_valid_nxt, skid_valid_nxt, load_main, load_skid, pop_skid;
   // in_fire can only happen with the skid empty, so pop_skid and load_main are mutually exclusive
   always_comb begin
      in_fire        = in_valid & in_ready;
      out_fire       = out_valid & out_ready;
      pop_skid       = ~flush & skid_valid & out_fire;
      load_main      = ~flush & in_fire & (~out_valid | out_fire);
      load_skid      = ~flush & in_fire & out_valid & ~out_fire;
      out_valid_nxt  = flush ? 1'b0 : skid_valid | in_fire | (out_valid & ~out_fire);
      skid_valid_nxt = flush ? 1'b0 : load_skid | (skid_valid & ~out_fire);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
         out_data   <= RESET_VAL;
         skid_data  <= '0;
      end else begin
         out_valid  <= out_valid_nxt;
         skid_valid <= skid_valid_nxt;
         in_ready   <= ~skid_valid_nxt;
         if (pop_skid) out_data <= skid_data;
         else if (load_main) out_data <= in_data;
         if (load_skid) skid_data <= in_data;
      end
   end
`ifdef PIPE_STAGE_REG_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (out_valid & ~out_ready) stall_cnt <= stall_cnt + 32'd1;
         if (flush & (out_valid | skid_valid)) flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: self-checking bench for pipe_stage_reg (directed table, corner sequences, random vs queue model)
module tb_pipe_stage_reg;
   localparam int W = 16;
   localparam logic [W-1:0] RV = 16'hBEEF;
   logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [W-1:0] in_data = '0;
   logic in_ready, out_valid;
   logic [W-1:0] out_data;
`ifdef PIPE_STAGE_REG_PERF_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif
   int n_chk = 0, n_fail = 0;
   logic [W-1:0] mq[$];
   logic [W-1:0] head_m = RV;
   int unsigned stall_m = 0, flush_m = 0;

   pipe_stage_reg #(.DATA_W(W), .RESET_VAL(RV)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_STAGE_REG_PERF_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic iv; logic [W-1:0] d; logic ordy; logic fl;
      logic ev; logic [W-1:0] ed; logic er;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: the stage is a FIFO of depth 2; out_data shows the oldest held entry, else the last one shown
   task automatic check_model();
      chk("out_valid", out_valid, mq.size() > 0);
      chk("in_ready", in_ready, mq.size() < 2);
      chk("out_data", out_data, head_m);
`ifdef PIPE_STAGE_REG_PERF_EN
      chk("stall_cnt", stall_cnt, stall_m);
      chk("flush_cnt", flush_cnt, flush_m);
`endif
   endtask

   task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
      bit inf, outf;
      in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
      inf  = iv && mq.size() < 2;
      outf = mq.size() > 0 && ordy;
      if (mq.size() > 0 && !ordy) stall_m++;
      if (fl && mq.size() > 0) flush_m++;
      if (fl) mq.delete();
      else begin
         if (outf) void'(mq.pop_front());
         if (inf) mq.push_back(d);
      end
      if (mq.size() > 0) head_m = mq[0];
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      mq.delete(); head_m = RV; stall_m = 0; flush_m = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_model();
   endtask

   vec_t tbl[$];

   initial begin
      tbl = '{
         '{1'b1, 16'h1, 1'b1, 1'b0, 1'b1, 16'h1, 1'b1},
         '{1'b1, 16'h2, 1'b1, 1'b0, 1'b1, 16'h2, 1'b1},
         '{1'b1, 16'h3, 1'b1, 1'b0, 1'b1, 16'h3, 1'b1},
         '{1'b0, 16'h7, 1'b1, 1'b0, 1'b0, 16'h3, 1'b1},
         '{1'b1, 16'hA, 1'b0, 1'b0, 1'b1, 16'hA, 1'b1},
         '{1'b1, 16'hB, 1'b0, 1'b0, 1'b1, 16'hA, 1'b0},
         '{1'b1, 16'hC, 1'b0, 1'b0, 1'b1, 16'hA, 1'b0},
         '{1'b1, 16'hC, 1'b1, 1'b0, 1'b1, 16'hB, 1'b1},
         '{1'b1, 16'hC, 1'b1, 1'b0, 1'b1, 16'hC, 1'b1},
         '{1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'hC, 1'b1},
         '{1'b1, 16'hA, 1'b0, 1'b0, 1'b1, 16'hA, 1'b1},
         '{1'b1, 16'hB, 1'b0, 1'b0, 1'b1, 16'hA, 1'b0},
         '{1'b1, 16'hC, 1'b0, 1'b1, 1'b0, 16'hA, 1'b1},
         '{1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'hA, 1'b1},
         '{1'b1, 16'h5, 1'b0, 1'b0, 1'b1, 16'h5, 1'b1},
         '{1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h5, 1'b1},
         '{1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h5, 1'b1},
         '{1'b0, 16'h1, 1'b1, 1'b0, 1'b0, 16'h5, 1'b1},
         '{1'b1, 16'h6, 1'b1, 1'b0, 1'b1, 16'h6, 1'b1},
         '{1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h6, 1'b1},
         '{1'b1, 16'h7, 1'b0, 1'b0, 1'b1, 16'h7, 1'b1},
         '{1'b1, 16'h8, 1'b0, 1'b1, 1'b0, 16'h7, 1'b1},
         '{1'b0, 16'h9, 1'b1, 1'b0, 1'b0, 16'h7, 1'b1}
      };
      do_reset();
      foreach (tbl[i]) begin
         step(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
         chk($sformatf("vec%0d.out_valid", i), out_valid, tbl[i].ev);
         chk($sformatf("vec%0d.out_data", i), out_data, tbl[i].ed);
         chk($sformatf("vec%0d.in_ready", i), in_ready, tbl[i].er);
      end
      // asynchronous reset asserted mid-cycle while two entries are held
      step(1'b1, 16'hA, 1'b0, 1'b0);
      step(1'b1, 16'hB, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst.out_valid", out_valid, 1'b0);
      chk("async_rst.out_data", out_data, RV);
      chk("async_rst.in_ready", in_ready, 1'b1);
      do_reset();
      step(1'b0, 16'h0, 1'b1, 1'b0);
      chk("post_rst.out_valid", out_valid, 1'b0);
      // counters: 7 stalled cycles, then 2 flushes with data held and 1 with nothing held
      step(1'b1, 16'h1, 1'b0, 1'b0);
      repeat (7) step(1'b0, 16'h0, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b1);
      step(1'b1, 16'h2, 1'b1, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b1);
      step(1'b0, 16'h0, 1'b1, 1'b1);
`ifdef PIPE_STAGE_REG_PERF_EN
      chk("stall_cnt_7", stall_cnt, 32'd7);
      chk("flush_cnt_2", flush_cnt, 32'd2);
`endif
      do_reset();
      for (int c = 0; c < 10000; c++)
         step($urandom_range(0, 9) < 6, W'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
